// File: rtl/eth_tx_src_arb.sv
// Frame-aware N-channel TX source arbiter: per-channel FWFT FIFOs, one whole frame per grant,
// programmable inter-frame gap before the next arbitration.
module eth_tx_src_arb #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ARB_MODE   = 0,
  parameter int unsigned IFG_CYCLES = 12,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 Clk,
  input  logic                 Rstn,
  input  logic [NUM_CH*10-1:0] Ch_Byte,
  input  logic [NUM_CH-1:0]    Ch_Byte_Valid,
  input  logic [NUM_CH-1:0]    Ch_En,
  input  logic                 Clr_Ovf,
  output logic [9:0]           Out_Byte,
  output logic                 Out_Byte_Valid,
  input  logic                 Out_Rdy,
  output logic [CH_W-1:0]      Active_Ch,
  output logic                 Busy,
  output logic [NUM_CH-1:0]    Ch_Ovf,
  output logic [15:0]          Frame_Cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [AW:0] PtrOne = 1;

  typedef enum logic [1:0] {StIdle, StXfer, StGap} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   act_q, act_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [15:0]       fcnt_q, fcnt_d;
  logic [NUM_CH-1:0] ovf_q;

  logic [9:0]        mem_q  [NUM_CH][FIFO_DEPTH];
  logic [AW:0]       wptr_q [NUM_CH];
  logic [AW:0]       rptr_q [NUM_CH];
  logic [9:0]        head   [NUM_CH];
  logic [NUM_CH-1:0] full, empty, push, pop, cand, discard, xfer_pop;

  logic              any_cand, found;
  logic [CH_W-1:0]   grant, rr_next;
  logic              out_valid;
  logic [9:0]        out_byte;

  // Full/empty come straight from the registered pointers; the extra MSB disambiguates wrap.
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      empty[i]   = (wptr_q[i] == rptr_q[i]);
      full[i]    = (wptr_q[i][AW] != rptr_q[i][AW]) &&
                   (wptr_q[i][AW-1:0] == rptr_q[i][AW-1:0]);
      head[i]    = mem_q[i][rptr_q[i][AW-1:0]];
      push[i]    = Ch_Byte_Valid[i] & ~full[i];
      cand[i]    = Ch_En[i] & ~empty[i] & head[i][8];
      discard[i] = (state_q == StIdle) & Ch_En[i] & ~empty[i] & ~head[i][8];
    end
  end

  assign pop = discard | xfer_pop;

  always_ff @(posedge Clk) begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (push[i]) mem_q[i][wptr_q[i][AW-1:0]] <= Ch_Byte[10*i +: 10];
    end
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + PtrOne;
        if (pop[i])  rptr_q[i] <= rptr_q[i] + PtrOne;
      end
      // A new overflow in the same cycle as a clear must survive.
      ovf_q <= (ovf_q & ~{NUM_CH{Clr_Ovf}}) | (Ch_Byte_Valid & full);
    end
  end

  always_comb begin
    any_cand = |cand;
    grant    = '0;
    found    = 1'b0;
    if (ARB_MODE == 0) begin
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
        if (cand[i]) grant = CH_W'(i);
      end
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        int unsigned idx;
        idx = (32'(rr_q) + k) % NUM_CH;
        if (!found && cand[CH_W'(idx)]) begin
          grant = CH_W'(idx);
          found = 1'b1;
        end
      end
    end
    if (32'(grant) == NUM_CH - 1) rr_next = '0;
    else                          rr_next = grant + CH_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    rr_d      = rr_q;
    gap_d     = gap_q;
    fcnt_d    = fcnt_q;
    xfer_pop  = '0;
    out_valid = 1'b0;
    out_byte  = '0;
    unique case (state_q)
      StIdle: begin
        if (any_cand) begin
          act_d   = grant;
          state_d = StXfer;
          if (ARB_MODE == 1) rr_d = rr_next;
        end
      end
      StXfer: begin
        out_valid = ~empty[act_q];
        if (out_valid) out_byte = head[act_q];
        if (out_valid && Out_Rdy) begin
          xfer_pop[act_q] = 1'b1;
          if (head[act_q][9]) begin
            fcnt_d = fcnt_q + 16'd1;
            if (IFG_CYCLES > 0) begin
              state_d = StGap;
              gap_d   = GW'(IFG_CYCLES - 1);
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      StGap: begin
        if (gap_q == '0) state_d = StIdle;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state_q <= StIdle;
      act_q   <= '0;
      rr_q    <= '0;
      gap_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign Out_Byte       = out_byte;
  assign Out_Byte_Valid = out_valid;
  assign Active_Ch      = act_q;
  assign Busy           = (state_q != StIdle);
  assign Ch_Ovf         = ovf_q;
  assign Frame_Cnt      = fcnt_q;

endmodule

// File: tb/tb_eth_tx_src_arb.sv
// Scoreboard bench: a fixed-priority and a round-robin arbiter share one stimulus bus;
// expected frames are queued in the order the arbitration rules dictate.
module tb_eth_tx_src_arb;

  localparam int IFG_FP = 12;
  localparam int IFG_RR = 3;

  typedef struct packed {logic ch; logic [9:0] w;} exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [19:0] ch_byte = '0;
  logic [1:0]  ch_valid = '0;
  logic [1:0]  ch_en = 2'b11;
  logic        clr_ovf = 1'b0;
  logic        out_rdy = 1'b1;
  logic        sel = 1'b0;
  logic        rdy_rand = 1'b0;
  logic        rdy_fixed = 1'b1;
  logic [1:0]  v_fp, v_rr;

  logic [9:0]  ob_fp, ob_rr;
  logic        obv_fp, obv_rr, ac_fp, ac_rr, busy_fp, busy_rr;
  logic [1:0]  ovf_fp, ovf_rr;
  logic [15:0] fc_fp, fc_rr;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int fc_exp [2] = '{0, 0};
  int rr_ptr = 0;
  int last_eof [2] = '{-1000, -1000};
  int gap_meas [2] = '{0, 0};
  logic       prev_v [2] = '{1'b0, 1'b0};
  logic       prev_r [2] = '{1'b0, 1'b0};
  logic [9:0] prev_w [2] = '{10'h0, 10'h0};
  logic [11:0] hist_fp [0:8191];

  exp_t       q_fp[$];
  exp_t       q_rr[$];
  logic [9:0] wq0[$];
  logic [9:0] wq1[$];

  assign v_fp = sel ? 2'b00 : ch_valid;
  assign v_rr = sel ? ch_valid : 2'b00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  eth_tx_src_arb #(.NUM_CH(2), .FIFO_DEPTH(16), .ARB_MODE(0), .IFG_CYCLES(IFG_FP)) u_fp (
    .Clk(clk), .Rstn(rstn), .Ch_Byte(ch_byte), .Ch_Byte_Valid(v_fp), .Ch_En(ch_en),
    .Clr_Ovf(clr_ovf), .Out_Byte(ob_fp), .Out_Byte_Valid(obv_fp), .Out_Rdy(out_rdy),
    .Active_Ch(ac_fp), .Busy(busy_fp), .Ch_Ovf(ovf_fp), .Frame_Cnt(fc_fp)
  );

  eth_tx_src_arb #(.NUM_CH(2), .FIFO_DEPTH(16), .ARB_MODE(1), .IFG_CYCLES(IFG_RR)) u_rr (
    .Clk(clk), .Rstn(rstn), .Ch_Byte(ch_byte), .Ch_Byte_Valid(v_rr), .Ch_En(ch_en),
    .Clr_Ovf(clr_ovf), .Out_Byte(ob_rr), .Out_Byte_Valid(obv_rr), .Out_Rdy(out_rdy),
    .Active_Ch(ac_rr), .Busy(busy_rr), .Ch_Ovf(ovf_rr), .Frame_Cnt(fc_rr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stimulus driver: one word per channel per cycle, inputs change 2 time units after the edge.
  initial forever begin
    @(posedge clk);
    #2;
    ch_valid = '0;
    ch_byte  = '0;
    if (wq0.size() != 0) begin ch_byte[9:0]   = wq0.pop_front(); ch_valid[0] = 1'b1; end
    if (wq1.size() != 0) begin ch_byte[19:10] = wq1.pop_front(); ch_valid[1] = 1'b1; end
    out_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  task automatic mon(input int d, input logic v, input logic [9:0] w, input logic a);
    exp_t e;
    if (prev_v[d] && !prev_r[d]) chk($sformatf("hold%0d", d), {v, w}, {1'b1, prev_w[d]});
    if (v && out_rdy) begin
      if ((d == 0 ? q_fp.size() : q_rr.size()) == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected%0d: got word 0x%0h, expected no transfer (cycle %0d)", d, w, cyc);
      end else begin
        if (d == 0) e = q_fp.pop_front();
        else        e = q_rr.pop_front();
        chk($sformatf("data%0d", d), 32'(w), 32'(e.w));
        chk($sformatf("active_ch%0d", d), 32'(a), 32'(e.ch));
      end
      if (w[8]) gap_meas[d] = cyc - last_eof[d];
      if (w[9]) last_eof[d] = cyc;
    end
    prev_v[d] = v;
    prev_r[d] = out_rdy;
    prev_w[d] = w;
  endtask

  always @(negedge clk) begin
    if (cyc < 8192) hist_fp[cyc] = {busy_fp, obv_fp, ob_fp};
    if (rstn) begin
      mon(0, obv_fp, ob_fp, ac_fp);
      mon(1, obv_rr, ob_rr, ac_rr);
    end else begin
      prev_v = '{1'b0, 1'b0};
    end
  end

  task automatic put(input int ch, input logic [9:0] w, input int d);
    exp_t e;
    e.ch = ch[0];
    e.w  = w;
    if (ch == 0) wq0.push_back(w);
    else         wq1.push_back(w);
    if (d == 0) q_fp.push_back(e);
    if (d == 1) q_rr.push_back(e);
    if (d >= 0 && w[9]) fc_exp[d]++;
  endtask

  task automatic send(input int ch, input int len, input int d);
    for (int i = 0; i < len; i++) put(ch, {i == len - 1, i == 0, 8'($urandom)}, d);
  endtask

  // Frames offered together: fixed priority takes ch0 first, round robin starts at the pointer.
  task automatic send_set(input int mask, input int d);
    int first;
    if (mask == 3) begin
      first = (d == 1) ? rr_ptr : 0;
      send(first, $urandom_range(1, 8), d);
      send(1 - first, $urandom_range(1, 8), d);
      if (d == 1) rr_ptr = first;
    end else begin
      first = (mask == 1) ? 0 : 1;
      send(first, $urandom_range(1, 8), d);
      if (d == 1) rr_ptr = 1 - first;
    end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((q_fp.size() != 0 || q_rr.size() != 0 || wq0.size() != 0 || wq1.size() != 0 ||
            busy_fp || busy_rr) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({nm, "_drain_timeout"}, 32'(n < 3000), 32'd1);
    chk({nm, "_frame_cnt_fp"}, 32'(fc_fp), 32'(fc_exp[0] & 16'hffff));
    chk({nm, "_frame_cnt_rr"}, 32'(fc_rr), 32'(fc_exp[1] & 16'hffff));
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int t;
    int n;
    logic [9:0] w2;

    #1 rstn = 1'b0;
    #1;
    chk("reset_fp", {obv_fp, ob_fp, ac_fp, busy_fp, ovf_fp, fc_fp}, 32'd0);
    chk("reset_rr", {obv_rr, ob_rr, ac_rr, busy_rr, ovf_rr, fc_rr}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Single 4-word frame: latency, ordering and gap length
    @(posedge clk);
    #1;
    t = cyc;
    put(0, 10'h155, 0);
    put(0, 10'h0AA, 0);
    put(0, 10'h001, 0);
    put(0, 10'h202, 0);
    drain("t1");
    chk("t1_valid_t+1", 32'(hist_fp[t+1][10]), 32'd0);
    chk("t1_first_t+2", 32'(hist_fp[t+2][10:0]), 32'h555);
    chk("t1_eof_t+5", 32'(hist_fp[t+5][10:0]), 32'h602);
    chk("t1_gap_start", 32'(hist_fp[t+6][11:10]), 32'h2);
    chk("t1_gap_end", 32'(hist_fp[t+17][11]), 32'd1);
    chk("t1_idle", 32'(hist_fp[t+18][11]), 32'd0);

    // Two channels contend: fixed priority serves ch0 then ch1 after the gap
    send(0, 2, 0);
    send(1, 2, 0);
    drain("t2");
    chk("t2_gap_fp", 32'(gap_meas[0]), 32'(IFG_FP + 2));
    send(0, 2, 0);
    send(0, 2, 0);
    send(1, 2, 0);
    send(1, 2, 0);
    drain("t2b");

    // Round robin with both channels reloaded: 0,1,0,1
    sel = 1'b1;
    send(0, 2, 1);
    send(1, 2, 1);
    send(0, 2, 1);
    send(1, 2, 1);
    rr_ptr = 0;
    drain("t3");
    chk("t3_gap_rr", 32'(gap_meas[1]), 32'(IFG_RR + 2));
    sel = 1'b0;

    // Overflow: 20 words into a 16-deep FIFO with the sink stalled
    rdy_fixed = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++)
      put(0, {i == 15, i == 0, 8'(8'h30 + i)}, (i < 16) ? 0 : -1);
    repeat (24) @(negedge clk);
    chk("ovf_set", 32'(ovf_fp), 32'h1);
    @(posedge clk); #1 clr_ovf = 1'b1;
    @(posedge clk); #1 clr_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_clear", 32'(ovf_fp), 32'h0);
    @(posedge clk); #1 put(0, 10'h0FF, -1); clr_ovf = 1'b1;
    @(posedge clk); #1 clr_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_set_wins", 32'(ovf_fp), 32'h1);
    @(posedge clk); #1 clr_ovf = 1'b1;
    @(posedge clk); #1 clr_ovf = 1'b0;
    rdy_rand = 1'b1;
    drain("t4");
    chk("ovf_final", 32'(ovf_fp), 32'h0);

    // 8-byte frame under random back-pressure
    send(1, 8, 0);
    drain("t5");

    // Headless words are discarded, only the SOF frame goes out
    for (int i = 0; i < 3; i++) put(1, {1'($urandom_range(0, 1)), 1'b0, 8'($urandom)}, -1);
    send(1, 3, 0);
    drain("t6");

    // Random frame sets on either arbiter
    for (int it = 0; it < 30; it++) begin
      sel = 1'($urandom_range(0, 1));
      send_set($urandom_range(1, 3), sel ? 1 : 0);
      drain("rand");
    end
    sel = 1'b0;

    // Reset while word 3 of a 6-word ch1 frame is on the output
    rdy_rand  = 1'b0;
    rdy_fixed = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) put(1, {i == 5, i == 0, 8'(8'h10 + i)}, 0);
    w2 = 10'h012;
    n  = 0;
    while (!(obv_fp && ob_fp == w2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_word3_seen", 32'(n < 50), 32'd1);
    #1 rstn = 1'b0;
    wq0.delete();
    wq1.delete();
    #1;
    chk("rst_async_fp", {obv_fp, ob_fp, ac_fp, busy_fp, ovf_fp, fc_fp}, 32'd0);
    q_fp.delete();
    q_rr.delete();
    fc_exp = '{0, 0};
    rr_ptr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    send(0, 4, 0);
    drain("t8");

    chk("final_queues", 32'(q_fp.size() + q_rr.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eth_tx_src_arb.md
Name: eth_tx_src_arb

Overview:
Frame-aware N-channel source arbiter that replaces the fixed compile-time test/loopback TX data mux ahead of eth_tx. Each channel (test pattern generator, RX loopback, future DMA source) writes 10-bit byte words into its own FWFT FIFO. The arbiter grants one channel per frame, streams that whole frame to eth_tx, and never interleaves frames. It then enforces a programmable inter-frame idle gap before re-arbitrating.

Parameters:
NUM_CH, 2, number of source channels (>=1)
FIFO_DEPTH, 16, per-channel FIFO depth in words (power of 2, >=2)
ARB_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round robin
IFG_CYCLES, 12, idle cycles inserted after each frame's EOF (0 = none)

Ports:
Clk  in  1  single clock (Eth_Clk domain)
Rstn  in  1  asynchronous active-low reset
Ch_Byte  in  NUM_CH*10  channel i at [10i+9:10i]; [7:0] data, [8] SOF, [9] EOF
Ch_Byte_Valid  in  NUM_CH  per-channel write strobe, one word per cycle
Ch_En  in  NUM_CH  per-channel arbitration enable
Clr_Ovf  in  1  clears all Ch_Ovf bits
Out_Byte  out  10  word to eth_tx (same bit layout as Ch_Byte)
Out_Byte_Valid  out  1  Out_Byte valid
Out_Rdy  in  1  sink accepts; transfer = Out_Byte_Valid & Out_Rdy
Active_Ch  out  max(1,$clog2(NUM_CH))  currently/last granted channel
Busy  out  1  high when state != IDLE
Ch_Ovf  out  NUM_CH  sticky per-channel overflow flags
Frame_Cnt  out  16  frames completed (EOF transferred), wraps at 0xFFFF->0

Behaviour:
- Reset (async assert, sync release): all FIFOs flushed, state IDLE, Out_Byte_Valid=0, Out_Byte=0, Active_Ch=0, Busy=0, Ch_Ovf=0, Frame_Cnt=0, round-robin pointer=0.
- FIFO write: a valid word is written when the FIFO is not full. If the FIFO is full, the word is dropped and Ch_Ovf[i] is set. If set and Clr_Ovf occur in the same cycle, set wins.
- A word written in cycle t is visible at the FIFO head in t+1. FIFO full and empty are registered on pointers with a wrap bit.
- FSM states: IDLE, XFER, GAP.
- IDLE behaviour:
  - Candidate = Ch_En[i] & FIFO non-empty & head[8] (SOF).
  - Heads that are enabled, non-empty and lack SOF are discarded in IDLE, one pop per cycle per channel, to resync after overflow or reset.
  - If any candidate exists, register the grant in Active_Ch and go to XFER next cycle.
  - ARB_MODE 0: lowest-index candidate wins. ARB_MODE 1: first candidate at or after the pointer (modulo NUM_CH) wins; the pointer then moves to grant+1.
- XFER behaviour:
  - Out_Byte_Valid = granted FIFO non-empty; Out_Byte = granted head; pop on transfer.
  - Out_Byte = 0 whenever Out_Byte_Valid = 0.
  - While valid & !Out_Rdy, Out_Byte is held stable.
  - FIFO underrun mid-frame deasserts Out_Byte_Valid and stays in XFER; no timeout.
  - A SOF seen mid-frame is forwarded unchanged.
  - On EOF transfer: Frame_Cnt++, then go to GAP if IFG_CYCLES>0, else IDLE.
  - A word with both SOF and EOF is a 1-byte frame.
- Ch_En deassertion mid-frame has no effect; the frame completes. Ch_En gates only new grants.
- GAP behaviour: Out_Byte_Valid=0; counter runs IFG_CYCLES cycles, then IDLE. Exactly IFG_CYCLES idle cycles lie between the EOF transfer and the arbitration cycle.
- Latency: SOF written at cycle t into an idle system, with IDLE arbitration at t+1, gives the first Out_Byte_Valid at t+2.
- Writes into a channel's FIFO continue while another channel (or the same channel) is being read; simultaneous push and pop on a full FIFO is accepted only if not full at the write edge (no bypass).
- Reset mid-frame: immediate return to reset values; the partial frame is lost and never completed downstream.

Test Plan:
- Ch0 writes 4 words (SOF 0x55, 0xAA, 0x01, EOF 0x02) at t..t+3, Out_Rdy=1, IFG_CYCLES=12 -> Out_Byte_Valid at t+2..t+5 with the same words, Frame_Cnt=1, Busy stays high for 12 GAP cycles, then IDLE.
- Ch0 and ch1 both present 2-word frames in the same cycle:
  - ARB_MODE=0 -> ch0 frame, 12-cycle gap, ch1 frame; Active_Ch 0 then 1.
  - ARB_MODE=1 with each channel continuously reloading -> grant order 0,1,0,1.
- Out_Rdy=0, ch0 writes 20 words (FIFO_DEPTH=16) -> 16 stored, Ch_Ovf=2'b01. Pulse Clr_Ovf -> 0. Clr_Ovf on the same cycle as a new overflow -> stays 1.
- Out_Rdy toggles randomly during an 8-byte frame -> every word is delivered once, in order, and Out_Byte is stable whenever valid & !Out_Rdy.
- Ch1 writes 3 words without SOF, then a SOF frame -> the headless words are discarded in IDLE and only the SOF frame is output.
- Rstn asserted mid-XFER on word 3 of 6 -> all outputs at reset values asynchronously. After release, a new frame transfers cleanly and Frame_Cnt counts from 0.
